// File: rtl/hdmi_scanout_engine_if.sv
// Framebuffer read port between the scan-out engine (master) and the pixel memory (slave).
interface hdmi_scanout_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [DATA_W-1:0] fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
    modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/hdmi_scanout_engine.sv
// Pixel-clock scan-out engine: raw HS/VS/DE timing, scaled framebuffer addressing,
// and a timing pipe that lines sync/enable up with memory read data.
module hdmi_scanout_engine #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int SYNC_POLARITY   = 0,
    parameter int FRAME_X_SCALE   = 0,
    parameter int FRAME_Y_SCALE   = 0,
    parameter int DATA_W          = 16,
    parameter int RD_LATENCY      = 1,
    parameter logic [DATA_W-1:0] BLANK_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    hdmi_scanout_engine_if.master fb_if,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  de_o,
    output logic [DATA_W-1:0]     hdmi_d_o,
    output logic                  sof_o
);
    localparam int TOTAL_H      = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int TOTAL_V      = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int H_W          = $clog2(TOTAL_H);
    localparam int V_W          = $clog2(TOTAL_V);
    localparam int FB_X         = ACTIVE_H_PIXELS >> FRAME_X_SCALE;
    localparam int FB_Y         = ACTIVE_LINES >> FRAME_Y_SCALE;
    localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y);

    // One spare bit so window bounds equal to TOTAL never wrap in the compare.
    localparam logic [H_W:0] H_ACT_END = (H_W+1)'(ACTIVE_H_PIXELS);
    localparam logic [H_W:0] HS_START  = (H_W+1)'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [H_W:0] HS_END    = (H_W+1)'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [V_W:0] V_ACT_END = (V_W+1)'(ACTIVE_LINES);
    localparam logic [V_W:0] VS_START  = (V_W+1)'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [V_W:0] VS_END    = (V_W+1)'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [H_W-1:0] X_MASK  = H_W'((1 << FRAME_X_SCALE) - 1);
    localparam logic [V_W-1:0] Y_MASK  = V_W'((1 << FRAME_Y_SCALE) - 1);
    localparam logic           POL     = (SYNC_POLARITY != 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic sof;
        logic hs;
        logic vs;
        logic de;
    } timing_t;

    state_t                  r_state, w_state_nxt;
    logic [H_W-1:0]          r_h;
    logic [V_W-1:0]          r_v;
    logic [FB_ADDR_BITS-1:0] r_addr, r_base;
    timing_t [RD_LATENCY-1:0] r_pipe;

    logic    w_run, w_h_last, w_v_last, w_active, w_line_end;
    logic    w_x_step, w_y_last, w_last_line;
    timing_t w_raw, w_out;

    assign w_run       = (r_state == S_RUN);
    assign w_h_last    = (r_h == H_W'(TOTAL_H - 1));
    assign w_v_last    = (r_v == V_W'(TOTAL_V - 1));
    assign w_active    = w_run && ({1'b0, r_h} < H_ACT_END) && ({1'b0, r_v} < V_ACT_END);
    assign w_line_end  = w_active && (r_h == H_W'(ACTIVE_H_PIXELS - 1));
    assign w_x_step    = ((r_h & X_MASK) == X_MASK);
    assign w_y_last    = ((r_v & Y_MASK) == Y_MASK);
    assign w_last_line = (r_v == V_W'(ACTIVE_LINES - 1));

    assign w_raw.de  = w_active;
    assign w_raw.hs  = w_run && ({1'b0, r_h} >= HS_START) && ({1'b0, r_h} < HS_END);
    assign w_raw.vs  = w_run && ({1'b0, r_v} >= VS_START) && ({1'b0, r_v} < VS_END);
    assign w_raw.sof = w_run && (r_h == '0) && (r_v == '0);

    // en_i is only honoured on the last cycle of a frame so a frame always completes.
    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_h_last && w_v_last && !en_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run || w_h_last) begin
                r_h <= '0;
                r_v <= (!w_run || w_v_last) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Incremental addressing: line start reloads base, the last repeat of a line moves base on.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr <= '0;
            r_base <= '0;
        end else if (!w_run) begin
            r_addr <= '0;
            r_base <= '0;
        end else if (w_line_end) begin
            if (w_y_last && w_last_line) begin
                r_addr <= '0;
                r_base <= '0;
            end else if (w_y_last) begin
                r_addr <= r_base + FB_ADDR_BITS'(FB_X);
                r_base <= r_base + FB_ADDR_BITS'(FB_X);
            end else begin
                r_addr <= r_base;
            end
        end else if (w_active && w_x_step) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pipe <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
            r_pipe[0] <= w_raw;
        end
    end

    assign w_out = r_pipe[RD_LATENCY-1];

    assign fb_if.fb_rd_en   = w_active;
    assign fb_if.fb_rd_addr = r_addr;

    assign de_o     = w_out.de;
    assign sof_o    = w_out.sof;
    assign hs_o     = w_out.hs ? POL : ~POL;
    assign vs_o     = w_out.vs ? POL : ~POL;
    assign hdmi_d_o = w_out.de ? fb_if.fb_rd_data : BLANK_VALUE;
endmodule

// File: tb/tb_hdmi_scanout_engine.sv
// Two engine instances (unscaled/latency 1/active-low and 2x2-scaled/latency 3/active-high)
// checked every cycle against a frame-position reference model.
module tb_hdmi_scanout_engine;
    localparam int AH = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int AL = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int TH = AH + HFP + HSW + HBP;
    localparam int TV = AL + VFP + VSW + VBP;
    localparam int TOTAL = TH * TV;
    localparam logic [15:0] BLANK_B = 16'hBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    hdmi_scanout_engine_if #(.ADDR_W(5), .DATA_W(16)) fb_a ();
    hdmi_scanout_engine_if #(.ADDR_W(3), .DATA_W(16)) fb_b ();

    logic hs_a, vs_a, de_a, sof_a, hs_b, vs_b, de_b, sof_b;
    logic [15:0] d_a, d_b;

    hdmi_scanout_engine #(
        .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
        .SYNC_POLARITY(0), .FRAME_X_SCALE(0), .FRAME_Y_SCALE(0), .DATA_W(16),
        .RD_LATENCY(1), .BLANK_VALUE(16'h0000)
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .fb_if(fb_a),
        .hs_o(hs_a), .vs_o(vs_a), .de_o(de_a), .hdmi_d_o(d_a), .sof_o(sof_a)
    );

    hdmi_scanout_engine #(
        .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
        .SYNC_POLARITY(1), .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1), .DATA_W(16),
        .RD_LATENCY(3), .BLANK_VALUE(BLANK_B)
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .fb_if(fb_b),
        .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b), .hdmi_d_o(d_b), .sof_o(sof_b)
    );

    // Memories return data equal to the address, after 1 and 3 cycles respectively.
    logic [15:0] mem_a_q;
    logic [15:0] mem_b_q [3];
    always_ff @(posedge clk) begin
        mem_a_q    <= 16'(fb_a.fb_rd_addr);
        mem_b_q[0] <= 16'(fb_b.fb_rd_addr);
        mem_b_q[1] <= mem_b_q[0];
        mem_b_q[2] <= mem_b_q[1];
    end
    assign fb_a.fb_rd_data = mem_a_q;
    assign fb_b.fb_rd_data = mem_b_q[2];

    logic        o_rd_en [2], o_de [2], o_hs [2], o_vs [2], o_sof [2];
    logic [31:0] o_addr [2], o_d [2];
    assign o_rd_en[0] = fb_a.fb_rd_en;  assign o_rd_en[1] = fb_b.fb_rd_en;
    assign o_addr[0]  = 32'(fb_a.fb_rd_addr); assign o_addr[1] = 32'(fb_b.fb_rd_addr);
    assign o_de[0] = de_a;   assign o_de[1] = de_b;
    assign o_hs[0] = hs_a;   assign o_hs[1] = hs_b;
    assign o_vs[0] = vs_a;   assign o_vs[1] = vs_b;
    assign o_sof[0] = sof_a; assign o_sof[1] = sof_b;
    assign o_d[0] = 32'(d_a); assign o_d[1] = 32'(d_b);

    typedef struct {
        bit de, hs, vs, sof;
        int addr;
    } raw_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   m_run [2];
    int   m_pos [2];
    raw_t m_hist [2][4];  // [0] = this cycle's raw timing, [k] = k cycles ago

    function automatic int lat(int d);   return (d == 0) ? 1 : 3; endfunction
    function automatic int scl(int d);   return (d == 0) ? 0 : 1; endfunction
    function automatic int blank(int d); return (d == 0) ? 0 : int'(BLANK_B); endfunction

    // Raw timing at a frame position, straight from the video timing rules.
    function automatic raw_t model_raw(int d, bit run, int pos);
        raw_t r;
        int h = pos % TH;
        int v = pos / TH;
        r.de   = run && h < AH && v < AL;
        r.hs   = run && h >= AH + HFP && h < AH + HFP + HSW;
        r.vs   = run && v >= AL + VFP && v < AL + VFP + VSW;
        r.sof  = run && pos == 0;
        r.addr = r.de ? (v >> scl(d)) * (AH >> scl(d)) + (h >> scl(d)) : 0;
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 1'b0;
            m_pos[d] = 0;
            for (int i = 0; i < 4; i++) m_hist[d][i] = '{default: 0};
        end
    endtask

    task automatic model_edge(int d, bit en_s);
        if (!m_run[d]) begin
            if (en_s) begin m_run[d] = 1'b1; m_pos[d] = 0; end
        end else if (m_pos[d] == TOTAL - 1) begin
            m_pos[d] = 0;
            if (!en_s) m_run[d] = 1'b0;
        end else begin
            m_pos[d]++;
        end
        for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
        m_hist[d][0] = model_raw(d, m_run[d], m_pos[d]);
    endtask

    task automatic check_outputs(int d);
        raw_t now_r = m_hist[d][0];
        raw_t out_r = m_hist[d][lat(d)];
        bit   pol   = (d == 1);
        string sx   = (d == 0) ? "_a" : "_b";
        check({"rd_en", sx}, 32'(o_rd_en[d]), 32'(now_r.de));
        if (now_r.de) check({"addr", sx}, o_addr[d], now_r.addr);
        check({"de", sx}, 32'(o_de[d]), 32'(out_r.de));
        check({"hs", sx}, 32'(o_hs[d]), 32'(out_r.hs ? pol : !pol));
        check({"vs", sx}, 32'(o_vs[d]), 32'(out_r.vs ? pol : !pol));
        check({"sof", sx}, 32'(o_sof[d]), 32'(out_r.sof));
        check({"data", sx}, o_d[d], out_r.de ? out_r.addr : blank(d));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) for (int d = 0; d < 2; d++) model_edge(d, en);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must be idle before any clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check_outputs(d);
            check(d == 0 ? "addr_rst_a" : "addr_rst_b", o_addr[d], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, first_a, first_b, sof_seen;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            check_outputs(d);
            check(d == 0 ? "addr_rst_a" : "addr_rst_b", o_addr[d], 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) step();

        // Continuous run: sof spacing is one full frame.
        en = 1'b1;
        cnt = 0;
        while (!sof_a && cnt < 20) begin step(); cnt++; end
        check("sof_first", 32'(sof_a), 1);
        cnt = 0;
        do begin step(); cnt++; end while (!sof_a && cnt < 200);
        check("sof_period", cnt, TOTAL);
        repeat (2 * TOTAL) step();

        // Reset at a random point of a running frame, then stay idle with en low.
        repeat ($urandom_range(1, TOTAL - 2)) step();
        apply_reset();
        en = 1'b0;
        repeat (30) step();

        // en dropped at h=3, v=1: frame completes, then nothing more is output.
        en = 1'b1;
        cnt = 0;
        while (!(m_run[0] && m_pos[0] == TH + 3) && cnt < 300) begin step(); cnt++; end
        en = 1'b0;
        sof_seen = 0;
        repeat (TOTAL + 40) begin step(); sof_seen += int'(sof_a) + int'(sof_b); end
        check("sof_after_stop", sof_seen, 0);

        // Re-raise: sof appears RD_LATENCY cycles after the first RUN cycle.
        en = 1'b1;
        step();
        first_a = -1;
        first_b = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sof_a && first_a < 0) first_a = i + 1;
            if (sof_b && first_b < 0) first_b = i + 1;
        end
        check("sof_lat_a", first_a, 1);
        check("sof_lat_b", first_b, 3);

        // Random enable toggling with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 799) == 0) apply_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
